// File: rtl/sprite_layer_mixer.sv
// Sprite/background compositor: aligns per-layer hit flags with ROM colour data,
// picks the lowest-indexed opaque layer, and gathers per-frame collision statistics.
module sprite_layer_mixer #(
  parameter int                 NUM_LAYERS = 4,
  parameter int                 COLOR_W    = 6,
  parameter int                 ROM_LAT    = 2,
  parameter logic [COLOR_W-1:0] KEY        = 6'b110011,
  parameter int                 CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  input  logic                          valid,
  input  logic [NUM_LAYERS-1:0]         in_rect,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [COLOR_W-1:0]            bg_rgb,
  output logic [COLOR_W-1:0]            pix_rgb,
  output logic                          pix_valid,
  output logic [2:0]                    layer_sel,
  output logic [NUM_LAYERS-1:0]         coll_flags,
  output logic [CNT_W-1:0]              overlap_cnt,
  output logic                          coll_valid
);

  localparam logic [2:0] BG_SEL = 3'(NUM_LAYERS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
    return c;
  endfunction

  logic [ROM_LAT-1:0]    vld_pipe;
  logic [NUM_LAYERS-1:0] rect_pipe [ROM_LAT];
  logic [NUM_LAYERS-1:0] active_en;
  logic [NUM_LAYERS-1:0] acc;
  logic [CNT_W-1:0]      cnt;

  logic                  vld_al;
  logic [NUM_LAYERS-1:0] rect_al;
  logic [NUM_LAYERS-1:0] opaque;
  logic [COLOR_W-1:0]    win_rgb;
  logic [2:0]            win_sel;
  logic                  multi;
  logic [NUM_LAYERS-1:0] acc_nxt;
  logic [CNT_W-1:0]      cnt_nxt;

  // Stages 0..ROM_LAT-1: delay line matching the ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < ROM_LAT; i++) rect_pipe[i] <= '0;
    end else begin
      vld_pipe[0]  <= valid;
      rect_pipe[0] <= in_rect;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        rect_pipe[i] <= rect_pipe[i-1];
      end
    end
  end

  assign vld_al  = vld_pipe[ROM_LAT-1];
  assign rect_al = rect_pipe[ROM_LAT-1];

  // Aligned stage: opacity, priority select and overlap detection
  always_comb begin
    opaque  = '0;
    win_rgb = bg_rgb;
    win_sel = BG_SEL;
    for (int i = 0; i < NUM_LAYERS; i++)
      opaque[i] = rect_al[i] & active_en[i] & (layer_rgb[i*COLOR_W +: COLOR_W] != KEY);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        win_rgb = layer_rgb[i*COLOR_W +: COLOR_W];
        win_sel = 3'(i);
      end
    end
    if (!vld_al) begin
      win_rgb = '0;
      win_sel = BG_SEL;
    end
  end

  // Clearing the lowest set bit leaves something only when two or more layers are opaque
  assign multi   = vld_al && ((opaque & (opaque - NUM_LAYERS'(1))) != '0);
  assign acc_nxt = multi ? (acc | opaque) : acc;
  assign cnt_nxt = sat_inc(cnt, multi);

  // Output stage: composited pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_rgb   <= '0;
      pix_valid <= 1'b0;
      layer_sel <= BG_SEL;
    end else begin
      pix_rgb   <= win_rgb;
      pix_valid <= vld_al;
      layer_sel <= win_sel;
    end
  end

  // Frame bookkeeping: enable shadowing and collision accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_en   <= '1;
      acc         <= '0;
      cnt         <= '0;
      coll_flags  <= '0;
      overlap_cnt <= '0;
      coll_valid  <= 1'b0;
    end else begin
      coll_valid <= frame_tick;
      if (frame_tick) begin
        active_en   <= layer_en;
        coll_flags  <= acc_nxt;
        overlap_cnt <= cnt_nxt;
        acc         <= '0;
        cnt         <= '0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Directed bench for sprite_layer_mixer: default instance plus a CNT_W=4 instance
// sharing the same stimulus to exercise counter saturation.
module tb_sprite_layer_mixer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        valid;
  logic [3:0]  in_rect;
  logic [3:0]  layer_en;
  logic [23:0] layer_rgb;
  logic [5:0]  bg_rgb;

  logic [5:0]  pix_rgb;
  logic        pix_valid;
  logic [2:0]  layer_sel;
  logic [3:0]  coll_flags;
  logic [15:0] overlap_cnt;
  logic        coll_valid;

  logic [5:0]  pix_rgb4;
  logic        pix_valid4;
  logic [2:0]  layer_sel4;
  logic [3:0]  coll_flags4;
  logic [3:0]  overlap_cnt4;
  logic        coll_valid4;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] BG = 6'h2A;

  always #5 clk = ~clk;

  sprite_layer_mixer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .valid(valid),
    .in_rect(in_rect), .layer_en(layer_en), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid), .layer_sel(layer_sel),
    .coll_flags(coll_flags), .overlap_cnt(overlap_cnt), .coll_valid(coll_valid)
  );

  sprite_layer_mixer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .valid(valid),
    .in_rect(in_rect), .layer_en(layer_en), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .pix_rgb(pix_rgb4), .pix_valid(pix_valid4), .layer_sel(layer_sel4),
    .coll_flags(coll_flags4), .overlap_cnt(overlap_cnt4), .coll_valid(coll_valid4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    valid      = 1'b0;
    in_rect    = 4'b0000;
    layer_en   = 4'b1111;
    // layer3=000001 layer2=111111 layer1=001100 layer0=KEY
    layer_rgb  = {6'h01, 6'h3F, 6'h0C, 6'h33};
    bg_rgb     = BG;
    tick();
    tick();
    check("rst_pix_rgb", 32'(pix_rgb), 32'h0);
    check("rst_pix_valid", 32'(pix_valid), 32'h0);
    check("rst_layer_sel", 32'(layer_sel), 32'd4);
    check("rst_coll_flags", 32'(coll_flags), 32'h0);
    check("rst_overlap_cnt", 32'(overlap_cnt), 32'h0);
    check("rst_coll_valid", 32'(coll_valid), 32'h0);
    rst_n = 1'b1;
    tick();

    // Keyed layer 0 under opaque layer 1; result three cycles later
    valid = 1'b1; in_rect = 4'b0011;
    tick();
    valid = 1'b0; in_rect = 4'b0000;
    check("lat_pv_c1", 32'(pix_valid), 32'h0);
    tick();
    check("lat_pv_c2", 32'(pix_valid), 32'h0);
    tick();
    check("key_pix_rgb", 32'(pix_rgb), 32'h0C);
    check("key_layer_sel", 32'(layer_sel), 32'd1);
    check("key_pix_valid", 32'(pix_valid), 32'h1);
    tick();
    check("idle_pix_rgb", 32'(pix_rgb), 32'h0);
    check("idle_layer_sel", 32'(layer_sel), 32'd4);

    // Only a keyed layer hit: background shows through
    valid = 1'b1; in_rect = 4'b0001;
    tick();
    valid = 1'b0; in_rect = 4'b0000;
    tick(); tick();
    check("bg_pix_rgb", 32'(pix_rgb), 32'(BG));
    check("bg_layer_sel", 32'(layer_sel), 32'd4);

    // Layers 0 and 2 overlap on 5 pixels
    layer_rgb[5:0] = 6'h05;
    valid = 1'b1; in_rect = 4'b0101;
    tick(); tick(); tick();
    check("ovl_pix_rgb", 32'(pix_rgb), 32'h05);
    check("ovl_layer_sel", 32'(layer_sel), 32'd0);
    tick(); tick();
    valid = 1'b0; in_rect = 4'b0000;
    tick(); tick(); tick();
    check("pre_tick_coll_valid", 32'(coll_valid), 32'h0);
    pulse_tick();
    check("f1_coll_valid", 32'(coll_valid), 32'h1);
    check("f1_coll_flags", 32'(coll_flags), 32'b0101);
    check("f1_overlap_cnt", 32'(overlap_cnt), 32'd5);
    check("f1_overlap_cnt4", 32'(overlap_cnt4), 32'd5);
    tick();
    check("f1_coll_valid_drop", 32'(coll_valid), 32'h0);

    // Disabling layer 0 mid-frame only takes effect after frame_tick
    valid = 1'b1; in_rect = 4'b0001; layer_en = 4'b1110;
    tick(); tick(); tick();
    check("en_mid_pix_rgb", 32'(pix_rgb), 32'h05);
    pulse_tick();
    check("en_edge_pix_rgb", 32'(pix_rgb), 32'h05);
    check("en_edge_layer_sel", 32'(layer_sel), 32'd0);
    check("f2_coll_valid", 32'(coll_valid), 32'h1);
    check("f2_coll_flags", 32'(coll_flags), 32'h0);
    check("f2_overlap_cnt", 32'(overlap_cnt), 32'h0);
    tick();
    check("en_off_pix_rgb", 32'(pix_rgb), 32'(BG));
    check("en_off_layer_sel", 32'(layer_sel), 32'd4);
    valid = 1'b0; in_rect = 4'b0000; layer_en = 4'b1111;
    tick(); tick(); tick();
    pulse_tick();
    tick();

    // Overlap pixel reaches the aligned stage on the frame_tick cycle
    valid = 1'b1; in_rect = 4'b0101;
    tick();
    valid = 1'b0; in_rect = 4'b0000;
    tick();
    pulse_tick();
    check("coinc_coll_valid", 32'(coll_valid), 32'h1);
    check("coinc_coll_flags", 32'(coll_flags), 32'b0101);
    check("coinc_overlap_cnt", 32'(overlap_cnt), 32'd1);
    check("coinc_overlap_cnt4", 32'(overlap_cnt4), 32'd1);
    tick();
    check("coinc_coll_valid_drop", 32'(coll_valid), 32'h0);
    pulse_tick();
    check("next_coll_flags", 32'(coll_flags), 32'h0);
    check("next_overlap_cnt", 32'(overlap_cnt), 32'h0);

    // 20 overlaps: 4-bit counter saturates at 15
    valid = 1'b1; in_rect = 4'b0101;
    for (int i = 0; i < 20; i++) tick();
    valid = 1'b0; in_rect = 4'b0000;
    tick(); tick(); tick();
    pulse_tick();
    check("sat_overlap_cnt", 32'(overlap_cnt), 32'd20);
    check("sat_overlap_cnt4", 32'(overlap_cnt4), 32'd15);
    check("sat_coll_flags4", 32'(coll_flags4), 32'b0101);
    tick();

    // Reset mid-frame with layer 0 disabled and a partial collision pending
    layer_en = 4'b1110;
    valid = 1'b1; in_rect = 4'b0101;
    tick(); tick(); tick();
    valid = 1'b0; in_rect = 4'b0000;
    tick(); tick(); tick();
    pulse_tick();
    check("pre_rst_coll_flags", 32'(coll_flags), 32'b0101);
    check("pre_rst_overlap_cnt", 32'(overlap_cnt), 32'd3);
    valid = 1'b1; in_rect = 4'b0110;
    tick(); tick(); tick();
    check("pre_rst_pix_rgb", 32'(pix_rgb), 32'h0C);
    check("pre_rst_layer_sel", 32'(layer_sel), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_pix_rgb", 32'(pix_rgb), 32'h0);
    check("arst_pix_valid", 32'(pix_valid), 32'h0);
    check("arst_layer_sel", 32'(layer_sel), 32'd4);
    check("arst_coll_flags", 32'(coll_flags), 32'h0);
    check("arst_overlap_cnt", 32'(overlap_cnt), 32'h0);
    check("arst_coll_valid", 32'(coll_valid), 32'h0);
    in_rect = 4'b0001; layer_en = 4'b1111;
    tick();
    check("arst_hold_pix_valid", 32'(pix_valid), 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_coll_valid_c1", 32'(coll_valid), 32'h0);
    tick();
    check("post_rst_coll_valid_c2", 32'(coll_valid), 32'h0);
    tick();
    check("post_rst_en_pix_rgb", 32'(pix_rgb), 32'h05);
    check("post_rst_en_layer_sel", 32'(layer_sel), 32'd0);
    check("post_rst_pix_valid", 32'(pix_valid), 32'h1);
    in_rect = 4'b0110;
    tick(); tick();
    valid = 1'b0; in_rect = 4'b0000;
    tick(); tick(); tick();
    check("post_rst_coll_valid_c3", 32'(coll_valid), 32'h0);
    pulse_tick();
    check("post_rst_f_coll_valid", 32'(coll_valid), 32'h1);
    check("post_rst_f_coll_flags", 32'(coll_flags), 32'b0110);
    check("post_rst_f_overlap_cnt", 32'(overlap_cnt), 32'd2);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
